// File: rtl/idu_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending-write counters
// with multi-port writeback, squash retirement, RAW/saturation stall and stats.
module idu_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned RIDX_W = 5,
    parameter int unsigned NWB    = 2,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    input  logic [RIDX_W-1:0]       dec_rs1,
    input  logic [RIDX_W-1:0]       dec_rs2,
    input  logic [RIDX_W-1:0]       dec_rd,
    input  logic                    dec_rd_wen,
    input  logic                    ex_ready,
    output logic                    stall,
    output logic                    issue,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*RIDX_W-1:0]   wb_rd,
    input  logic                    kill_valid,
    input  logic [RIDX_W-1:0]       kill_rd,
    output logic [NREG-1:0]         busy_vec,
    output logic [7:0]              outstanding,
    output logic [31:0]             stall_cycles,
    output logic                    underflow_err
);

    localparam int unsigned DEC_W   = $clog2(NWB + 2);
    localparam int unsigned SUM_W   = CNT_W + DEC_W + 1;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam int unsigned TOT_W   = 16;

    logic [CNT_W-1:0] count      [NREG];
    logic [CNT_W-1:0] count_next [NREG];
    logic [DEC_W-1:0] dec_cnt    [NREG];
    logic [NREG-1:0]  hz_vec;
    logic [NREG-1:0]  sat_vec;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  uflow_vec;
    logic [NREG-1:0]  busy_next;
    logic             haz1;
    logic             haz2;
    logic             sat;
    logic [SUM_W-1:0] sum;
    logic [TOT_W-1:0] eff_dec_total;
    logic [TOT_W-1:0] out_up;
    logic [TOT_W-1:0] out_diff;
    logic [7:0]       out_next;

    // Hazard/stall decode and next-state counter arithmetic
    always_comb begin
        hz_vec        = '0;
        sat_vec       = '0;
        inc_vec       = '0;
        uflow_vec     = '0;
        busy_next     = '0;
        haz1          = 1'b0;
        haz2          = 1'b0;
        sat           = 1'b0;
        stall         = 1'b0;
        issue         = 1'b0;
        sum           = '0;
        eff_dec_total = '0;
        out_up        = '0;
        out_diff      = '0;
        out_next      = outstanding;
        for (int r = 0; r < int'(NREG); r++) begin
            dec_cnt[r]    = '0;
            count_next[r] = '0;
        end

        for (int r = 1; r < int'(NREG); r++) begin
            for (int i = 0; i < int'(NWB); i++) begin
                if (wb_valid[i] && (wb_rd[i*RIDX_W +: RIDX_W] == RIDX_W'(r)))
                    dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
            end
            if (kill_valid && (kill_rd == RIDX_W'(r)))
                dec_cnt[r] = dec_cnt[r] + DEC_W'(1);

            if (BYPASS != 0)
                hz_vec[r] = SUM_W'(count[r]) > SUM_W'(dec_cnt[r]);
            else
                hz_vec[r] = count[r] != '0;
            sat_vec[r] = (count[r] == CNT_W'(CNT_MAX)) && (dec_cnt[r] == '0);
        end

        for (int r = 1; r < int'(NREG); r++) begin
            if (dec_rs1 == RIDX_W'(r)) haz1 = hz_vec[r];
            if (dec_rs2 == RIDX_W'(r)) haz2 = hz_vec[r];
            if (dec_rd_wen && (dec_rd == RIDX_W'(r))) sat = sat_vec[r];
        end

        stall = dec_valid & (haz1 | haz2 | sat);
        issue = dec_valid & ~stall & ex_ready;

        // Underflowed excess is dropped from the outstanding total
        for (int r = 1; r < int'(NREG); r++) begin
            inc_vec[r] = issue && dec_rd_wen && (dec_rd == RIDX_W'(r));
            sum = SUM_W'(count[r]) + SUM_W'(inc_vec[r]);
            if (sum < SUM_W'(dec_cnt[r])) begin
                uflow_vec[r]  = 1'b1;
                count_next[r] = '0;
                eff_dec_total = eff_dec_total + TOT_W'(sum);
            end else begin
                count_next[r] = CNT_W'(sum - SUM_W'(dec_cnt[r]));
                eff_dec_total = eff_dec_total + TOT_W'(dec_cnt[r]);
            end
            busy_next[r] = count_next[r] != '0;
        end

        out_up = TOT_W'(outstanding) + TOT_W'(|inc_vec);
        if (eff_dec_total >= out_up) begin
            out_next = 8'd0;
        end else begin
            out_diff = out_up - eff_dec_total;
            out_next = (out_diff > TOT_W'(255)) ? 8'd255 : 8'(out_diff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) count[r] <= '0;
            busy_vec      <= '0;
            outstanding   <= '0;
            stall_cycles  <= '0;
            underflow_err <= 1'b0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) count[r] <= count_next[r];
            busy_vec     <= busy_next;
            outstanding  <= out_next;
            stall_cycles <= stall_cycles + 32'(stall);
            if (|uflow_vec) underflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/idu_scoreboard.md
Name: idu_scoreboard

Overview:
- Parametrised register-hazard scoreboard that sits in the decode stage between instruction decode and the register-file read / EX issue point.
- Replaces the single-cycle load-use compare with a per-register pending-write counter table.
- Supports NWB writeback ports and multi-cycle producers (MUL/DIV, loads, AXI misses).
- Stalls decode on RAW hazards and on counter saturation; squashed producers are retired through a kill port.

Parameters:
- NREG, 32, number of architectural integer registers; x0 is never tracked.
- RIDX_W, 5, register index width; must satisfy 2^RIDX_W >= NREG.
- NWB, 2, number of writeback ports.
- CNT_W, 2, width of each pending counter; maximum outstanding writes per register = 2^CNT_W-1.
- BYPASS, 1, when 1, a same-cycle writeback that clears a register's last pending write also clears the hazard for that register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dec_valid  in  1  decode slot holds a valid instruction.
- dec_rs1  in  RIDX_W  source 1 index; 0 means unused.
- dec_rs2  in  RIDX_W  source 2 index; 0 means unused.
- dec_rd  in  RIDX_W  destination index.
- dec_rd_wen  in  1  instruction writes dec_rd.
- ex_ready  in  1  downstream can accept an issue this cycle.
- stall  out  1  decode must hold.
- issue  out  1  instruction issues this cycle.
- wb_valid  in  NWB  per-port writeback strobe.
- wb_rd  in  NWB*RIDX_W  per-port writeback index; port i occupies bits [i*RIDX_W +: RIDX_W].
- kill_valid  in  1  a squashed in-flight producer is retired.
- kill_rd  in  RIDX_W  destination of the squashed producer.
- busy_vec  out  NREG  bit r = 1 when count[r] != 0; bit 0 is always 0.
- outstanding  out  8  total pending writes across all registers, saturating at 255.
- stall_cycles  out  32  cycles with dec_valid & stall, wrapping.
- underflow_err  out  1  sticky error flag.

Behaviour:
- State: count[1..NREG-1] (CNT_W bits each), the stall_cycles counter, the outstanding register and the underflow_err flag. Every index-0 event is ignored.
- Reset (asynchronous, any cycle, including mid-operation): all counts 0, busy_vec 0, outstanding 0, stall_cycles 0, underflow_err 0. With no valid input, stall and issue are therefore 0.
- Decrement seen by source register r, dec_r = number of wb ports with wb_valid[i] && wb_rd[i]==r, plus kill_valid && kill_rd==r.
- Source hazard for r (r != 0):
  - BYPASS=0: hazard when count[r] != 0.
  - BYPASS=1: hazard when count[r] > dec_r.
- Saturation: sat = dec_rd_wen && dec_rd != 0 && count[dec_rd] == 2^CNT_W-1, with no same-cycle decrement to dec_rd.
- stall = dec_valid & (hazard(rs1) | hazard(rs2) | sat). This is combinational from registered state and the current wb/kill inputs.
- issue = dec_valid & ~stall & ex_ready. Decode holds whenever stall or ~ex_ready.
- Clock-edge update per register r: count[r] <= count[r] + inc_r - dec_r.
  - inc_r = issue & dec_rd_wen & (dec_rd == r).
  - Simultaneous increment and decrement on the same register nets out.
  - Duplicate wb indices in one cycle each decrement.
- Underflow: if count[r] + inc_r < dec_r, count[r] <= 0 and underflow_err <= 1 (sticky until reset).
- outstanding <= outstanding + total inc - total effective decrement, saturating at 0 and 255. The effective decrement excludes underflowed excess.
- stall_cycles increments every cycle with dec_valid & stall and wraps from 2^32-1 to 0.
- busy_vec and outstanding are registered: they reflect state after the previous edge, one cycle of latency.
- Hazard checks never consider dec_rd against itself (WAW is allowed; the counter handles ordering).

Test Plan:
- Reset then idle: assert rst for 2 cycles mid-traffic with count[5]=2 -> all outputs 0 immediately (asynchronous); after release, dec_valid=1, rs1=5, ex_ready=1 -> stall=0, issue=1.
- Load-use stall:
  - Issue rd=7 (dec_rd_wen=1), then next cycle rs1=7 -> stall=1, busy_vec[7]=1.
  - wb_valid[0]=1, wb_rd=7 with BYPASS=1 -> stall=0 in that same cycle; count[7]=0 after the edge.
- Multi-port and WAW:
  - Issue rd=3 twice -> count[3]=2, outstanding=2.
  - Both wb ports write rd=3 in one cycle -> count[3]=0, outstanding=0, underflow_err=0.
- Saturation (CNT_W=2): issue rd=9 three times -> count[9]=3; fourth rd=9 -> stall=1, stall_cycles increments; with wb to 9 in the same cycle -> issue=1, count stays 3.
- Kill and underflow:
  - kill_valid=1, kill_rd=4 with count[4]=1 -> count[4]=0.
  - Repeat -> count[4]=0, underflow_err=1 (sticky until reset).
- x0 and BYPASS=0: rs1=0 / dec_rd=0 traffic never sets busy_vec or stalls; with BYPASS=0 and count[6]=1 plus a same-cycle wb to 6 -> stall=1 that cycle, 0 the next.
